// File: rtl/ascii_operand_parser_pkg.sv
// ascii_pkg: shared ASCII character codes and parser state encoding.
package ascii_pkg;
    localparam int CHAR_W = 7;
    typedef logic [CHAR_W-1:0] char_t;
    localparam char_t ASCII_0     = 7'h30;
    localparam char_t ASCII_9     = 7'h39;
    localparam char_t ASCII_PLUS  = 7'h2B;
    localparam char_t ASCII_EQ    = 7'h3D;
    localparam char_t ASCII_SPACE = 7'h20;
    localparam char_t ASCII_ESC   = 7'h1B;
    typedef enum logic [2:0] {
        ST_A1,
        ST_A2,
        ST_PL,
        ST_B1,
        ST_B2,
        ST_EQ,
        ST_HOLD
    } state_t;
endpackage

// File: rtl/ascii_operand_parser_if.sv
// ascii_operand_parser_if: character input handshake plus operand output handshake.
interface ascii_operand_parser_if;
    import ascii_pkg::*;
    char_t in_char;
    logic  in_valid;
    logic  in_ready;
    char_t AD;
    char_t AU;
    char_t BD;
    char_t BU;
    logic  out_valid;
    logic  out_ready;
    logic  err;
    modport slave (
        input  in_char, in_valid, out_ready,
        output in_ready, AD, AU, BD, BU, out_valid, err
    );
    modport master (
        output in_char, in_valid, out_ready,
        input  in_ready, AD, AU, BD, BU, out_valid, err
    );
endinterface

// File: rtl/ascii_operand_parser_digit_check.sv
// ascii_digit_check: flags ASCII '0'..'9'.
module ascii_digit_check
    import ascii_pkg::*;
(
    input  char_t c,
    output logic  is_digit
);
    assign is_digit = (c >= ASCII_0) && (c <= ASCII_9);
endmodule

// File: rtl/ascii_operand_parser.sv
// ascii_operand_parser: assembles two ASCII two-digit operands from "AA+BB=" and holds them for the adder.
module ascii_operand_parser
    import ascii_pkg::*;
(
    input logic clk,
    input logic rst,
    ascii_operand_parser_if.slave bus
);
    state_t state;
    char_t  ad, au, bd, bu;
    logic   out_valid, err;
    logic   is_digit, is_space, is_esc, is_plus, is_eq;
    logic   accept, legal, abort;
    char_t  c;

    ascii_digit_check u_digit (
        .c        (bus.in_char),
        .is_digit (is_digit)
    );

    assign c        = bus.in_char;
    assign is_space = c == ASCII_SPACE;
    assign is_esc   = c == ASCII_ESC;
    assign is_plus  = c == ASCII_PLUS;
    assign is_eq    = c == ASCII_EQ;
    assign accept   = bus.in_valid && (state != ST_HOLD);
    assign legal    = is_space
                   || (is_digit && (state inside {ST_A1, ST_A2, ST_B1, ST_B2}))
                   || (is_plus && (state inside {ST_A2, ST_PL}))
                   || (is_eq && (state inside {ST_B2, ST_EQ}));
    // ESC and syntax errors share the abort path; only errors raise err
    assign abort    = accept && !legal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_A1;
            ad        <= ASCII_0;
            au        <= ASCII_0;
            bd        <= ASCII_0;
            bu        <= ASCII_0;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            err <= abort && !is_esc;
            if (state == ST_HOLD) begin
                if (bus.out_ready) begin
                    state     <= ST_A1;
                    out_valid <= 1'b0;
                end
            end else if (abort) begin
                state <= ST_A1;
                ad    <= ASCII_0;
                au    <= ASCII_0;
                bd    <= ASCII_0;
                bu    <= ASCII_0;
            end else if (accept && is_digit) begin
                if (state == ST_A1) begin
                    ad    <= ASCII_0;
                    au    <= c;
                    state <= ST_A2;
                end else if (state == ST_A2) begin
                    ad    <= au;
                    au    <= c;
                    state <= ST_PL;
                end else if (state == ST_B1) begin
                    bd    <= ASCII_0;
                    bu    <= c;
                    state <= ST_B2;
                end else begin
                    bd    <= bu;
                    bu    <= c;
                    state <= ST_EQ;
                end
            end else if (accept && is_plus) begin
                state <= ST_B1;
            end else if (accept && is_eq) begin
                state     <= ST_HOLD;
                out_valid <= 1'b1;
            end
        end
    end

    assign bus.in_ready  = state != ST_HOLD;
    assign bus.out_valid = out_valid;
    assign bus.err       = err;
    assign bus.AD        = ad;
    assign bus.AU        = au;
    assign bus.BD        = bd;
    assign bus.BU        = bu;
endmodule

// File: tb/tb_ascii_operand_parser.sv
// tb_ascii_operand_parser: directed checks of the ASCII operand parser.
module tb_ascii_operand_parser;
    logic clk = 1'b0;
    logic rst;
    int   compared = 0;
    int   mismatched = 0;
    logic err_seen;

    ascii_operand_parser_if bus ();

    ascii_operand_parser dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ops(input string tag, input logic [6:0] a_d, input logic [6:0] a_u,
                           input logic [6:0] b_d, input logic [6:0] b_u);
        chk({tag, " AD"}, 32'(bus.AD), 32'(a_d));
        chk({tag, " AU"}, 32'(bus.AU), 32'(a_u));
        chk({tag, " BD"}, 32'(bus.BD), 32'(b_d));
        chk({tag, " BU"}, 32'(bus.BU), 32'(b_u));
    endtask

    task automatic send_char(input logic [6:0] ch);
        bus.in_char  = ch;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        err_seen = err_seen | bus.err;
    endtask

    task automatic send_str(input string s);
        byte b;
        for (int i = 0; i < s.len(); i++) begin
            b = s[i];
            send_char(b[6:0]);
        end
    endtask

    task automatic ack();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_char   = 7'h00;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        err_seen      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset err", 32'(bus.err), 32'd0);
        chk_ops("reset", 7'h30, 7'h30, 7'h30, 7'h30);
        rst = 1'b0;

        send_str("47+85");
        chk("47+85 before eq out_valid", 32'(bus.out_valid), 32'd0);
        send_str("=");
        chk("47+85= out_valid", 32'(bus.out_valid), 32'd1);
        chk("47+85= in_ready", 32'(bus.in_ready), 32'd0);
        chk("47+85= no err", 32'(err_seen), 32'd0);
        chk_ops("47+85=", 7'h34, 7'h37, 7'h38, 7'h35);
        bus.in_char  = 7'h39;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("hold in_ready", 32'(bus.in_ready), 32'd0);
            chk("hold out_valid", 32'(bus.out_valid), 32'd1);
            chk_ops("hold", 7'h34, 7'h37, 7'h38, 7'h35);
        end
        ack();
        chk("release out_valid", 32'(bus.out_valid), 32'd0);
        chk("release in_ready", 32'(bus.in_ready), 32'd1);

        send_str("7+9=");
        chk("7+9= out_valid", 32'(bus.out_valid), 32'd1);
        chk_ops("7+9=", 7'h30, 7'h37, 7'h30, 7'h39);
        ack();

        err_seen = 1'b0;
        send_str(" 1 2 + 3 4 =");
        chk("spaces out_valid", 32'(bus.out_valid), 32'd1);
        chk("spaces no err", 32'(err_seen), 32'd0);
        chk_ops("spaces", 7'h31, 7'h32, 7'h33, 7'h34);
        ack();

        send_str("12");
        chk("12 no err", 32'(bus.err), 32'd0);
        send_str("3");
        chk("third digit err", 32'(bus.err), 32'd1);
        chk("third digit AU cleared", 32'(bus.AU), 32'h30);
        chk("third digit AD cleared", 32'(bus.AD), 32'h30);
        @(posedge clk);
        #1;
        chk("err one cycle", 32'(bus.err), 32'd0);
        chk("after err in_ready", 32'(bus.in_ready), 32'd1);
        send_str("99+99=");
        chk("99+99= out_valid", 32'(bus.out_valid), 32'd1);
        chk_ops("99+99=", 7'h39, 7'h39, 7'h39, 7'h39);
        ack();

        send_str("5A");
        chk("letter err", 32'(bus.err), 32'd1);
        send_str("4+");
        chk("4+ no err", 32'(bus.err), 32'd0);
        send_str("=");
        chk("eq in B1 err", 32'(bus.err), 32'd1);
        chk("eq in B1 out_valid", 32'(bus.out_valid), 32'd0);

        send_str("12+");
        send_char(7'h1B);
        chk("esc no err", 32'(bus.err), 32'd0);
        chk_ops("esc", 7'h30, 7'h30, 7'h30, 7'h30);
        send_str("1+1=");
        chk("1+1= out_valid", 32'(bus.out_valid), 32'd1);
        chk_ops("1+1=", 7'h30, 7'h31, 7'h30, 7'h31);
        ack();

        send_str("12+3");
        #2;
        rst = 1'b1;
        #1;
        chk("async rst mid AU", 32'(bus.AU), 32'h30);
        chk("async rst mid BU", 32'(bus.BU), 32'h30);
        chk("async rst mid in_ready", 32'(bus.in_ready), 32'd1);
        chk("async rst mid err", 32'(bus.err), 32'd0);
        #1;
        rst = 1'b0;
        send_str("1+2=");
        chk("pre-rst hold out_valid", 32'(bus.out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async rst hold out_valid", 32'(bus.out_valid), 32'd0);
        chk("async rst hold in_ready", 32'(bus.in_ready), 32'd1);
        chk_ops("async rst hold", 7'h30, 7'h30, 7'h30, 7'h30);
        #1;
        rst = 1'b0;
        send_str("3+4=");
        chk("post-rst out_valid", 32'(bus.out_valid), 32'd1);
        chk_ops("post-rst 3+4=", 7'h30, 7'h33, 7'h30, 7'h34);
        ack();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
